cm_arb: RTL and testbench
=========================

CM_ARB -- requirements
Module: cm_arb

Interface
REQ-001 The block SHALL provide parameter N, default 4, meaning number of input channels (legal 2..16).
REQ-002 The block SHALL provide parameter W, default 32, meaning data width per channel.
REQ-003 The block SHALL provide parameter ALGO, type cm_pkg::t_arb_algo, default ARB_MIN, meaning ARB_MIN grants lowest requesting index and ARB_MAX grants highest requesting index.
REQ-004 The block SHALL provide parameter PKT_LOCK, default 1, meaning 1 holds the grant until s_last and 0 releases the grant after every beat.
REQ-005 The block SHALL provide port clk, input, width 1, the single clock; all logic is on its rising edge.
REQ-006 The block SHALL provide port rst, input, width 1, a synchronous active-high reset.
REQ-007 The block SHALL provide port s_valid, input, width N, per-channel beat valid.
REQ-008 The block SHALL provide port s_ready, output, width N, per-channel beat accept.
REQ-009 The block SHALL provide port s_data, input, width N x W, per-channel payload.
REQ-010 The block SHALL provide port s_last, input, width N, per-channel end-of-packet.
REQ-011 The block SHALL provide port m_valid, output, width 1, registered output valid.
REQ-012 The block SHALL provide port m_ready, input, width 1, downstream accept.
REQ-013 The block SHALL provide port m_data, output, width W, registered payload.
REQ-014 The block SHALL provide port m_last, output, width 1, registered end-of-packet.
REQ-015 The block SHALL provide port m_sel, output, width max(1,$clog2(N)), source channel index of the current output beat.

Function
REQ-016 The FSM SHALL have exactly two states, IDLE and LOCK.
REQ-017 In IDLE, all s_ready bits SHALL be 0.
REQ-018 In IDLE, with any s_valid bit set, the block SHALL register grant index g per ALGO and enter LOCK next cycle.
REQ-019 In LOCK, s_ready[g] SHALL equal (!m_valid || m_ready) and all other s_ready bits SHALL be 0.
REQ-020 A transfer SHALL occur when s_valid[g] && s_ready[g]; on a transfer, m_valid is set to 1 and m_data/m_last/m_sel load s_data[g]/s_last[g]/g.
REQ-021 When m_valid && m_ready and no new transfer occurs in the same cycle, m_valid SHALL clear to 0.
REQ-022 A simultaneous output pop and input transfer SHALL reload the output register with m_valid held at 1, sustaining one beat per cycle with no bubble.
REQ-023 With PKT_LOCK=1, a transfer with s_last[g]=1 SHALL return the FSM to IDLE; otherwise the FSM stays in LOCK.
REQ-024 With PKT_LOCK=0, every transfer SHALL return the FSM to IDLE.
REQ-025 While in LOCK, the grant g SHALL NOT change, regardless of newly asserted higher-priority requests or s_valid[g] deasserting.
REQ-026 Latency SHALL be 2 cycles from s_valid rising in IDLE to m_valid: cycle 0 arbitrate, cycle 1 accept, cycle 2 output valid.
REQ-027 Each packet SHALL cost one IDLE arbitration cycle, so the maximum throughput for single-beat packets is 1 beat per 2 cycles.
REQ-028 While m_valid=1 and m_ready=0, m_data, m_last and m_sel SHALL be held stable.

Reset
REQ-029 While rst=1, the FSM SHALL be IDLE, g=0, m_valid=0, m_data=0, m_last=0, m_sel=0 and s_ready=0, all taking effect at the next clk edge.
REQ-030 Reset asserted mid-packet SHALL discard the lock and any held output beat; after release, arbitration restarts from IDLE.

Verification
REQ-031 The bench SHALL cover: N=4, ARB_MIN, s_valid=4'b1010 single-beat packets, m_ready=1 -> m_sel sequence 1,3 with m_valid first high 2 cycles after request.
REQ-032 The bench SHALL cover: N=4, ARB_MAX, s_valid=4'b0111 -> first grant index 2.
REQ-033 The bench SHALL cover: PKT_LOCK=1, ch0 sends a 4-beat packet while ch1 is asserted from beat 2 -> all 4 beats are m_sel=0 and contiguous at 1 beat per cycle, then ch1 is granted after one IDLE cycle.
REQ-034 The bench SHALL cover: m_ready held 0 for 5 cycles with a beat pending -> m_data stable, s_ready[g]=0, and no beat lost or duplicated after release.
REQ-035 The bench SHALL cover: PKT_LOCK=0, ch0 and ch2 both sending multi-beat packets under ARB_MIN -> ch0 is re-granted each beat and ch2 is granted only after ch0's s_valid drops.
REQ-036 The bench SHALL cover: rst pulsed for 1 cycle mid-packet -> next cycle m_valid=0 and s_ready=0, and a fresh arbitration occurs.

Source files
------------

// File: rtl/cm_arb.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | cm_arb : N-to-1 packet arbiter with a registered output stage       |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+

package cm_pkg;
  typedef enum logic [0:0] {ARB_MIN = 1'b0, ARB_MAX = 1'b1} t_arb_algo;
endpackage

module cm_arb #(
  parameter int                N        = 4,
  parameter int                W        = 32,
  parameter cm_pkg::t_arb_algo ALGO     = cm_pkg::ARB_MIN,
  parameter bit                PKT_LOCK = 1'b1,
  localparam int               SW       = (N > 1) ? $clog2(N) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   s_valid,
  output logic [N-1:0]   s_ready,
  input  logic [N*W-1:0] s_data,
  input  logic [N-1:0]   s_last,
  output logic           m_valid,
  input  logic           m_ready,
  output logic [W-1:0]   m_data,
  output logic           m_last,
  output logic [SW-1:0]  m_sel
);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_LOCK = 1'b1} t_state;

  t_state        state_q, state_d;
  logic [SW-1:0] g_q, g_d;
  logic [SW-1:0] w_pick;
  logic          m_valid_q;
  logic [W-1:0]  m_data_q;
  logic          m_last_q;
  logic [SW-1:0] m_sel_q;
  logic          w_out_free;
  logic          w_xfer;
  logic [W-1:0]  w_data_arr [N];

  for (genvar i = 0; i < N; i++) begin : g_slice
    assign w_data_arr[i] = s_data[i*W +: W];
  end

  // Later loop iterations overwrite earlier ones, so scan order sets priority.
  if (ALGO == cm_pkg::ARB_MIN) begin : g_min
    always_comb begin
      w_pick = '0;
      for (int i = N - 1; i >= 0; i--) begin
        if (s_valid[i]) w_pick = SW'(i);
      end
    end
  end else begin : g_max
    always_comb begin
      w_pick = '0;
      for (int i = 0; i < N; i++) begin
        if (s_valid[i]) w_pick = SW'(i);
      end
    end
  end

  assign w_out_free = !m_valid_q || m_ready;

  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    s_ready = '0;
    w_xfer  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (|s_valid) begin
          g_d     = w_pick;
          state_d = S_LOCK;
        end
      end
      S_LOCK: begin
        s_ready[g_q] = w_out_free;
        w_xfer       = s_valid[g_q] && w_out_free;
        if (w_xfer && (!PKT_LOCK || s_last[g_q])) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      g_q       <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_last_q  <= 1'b0;
      m_sel_q   <= '0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      // A load on the same cycle as a pop keeps m_valid high: no bubble.
      if (w_xfer) begin
        m_valid_q <= 1'b1;
        m_data_q  <= w_data_arr[g_q];
        m_last_q  <= s_last[g_q];
        m_sel_q   <= g_q;
      end else if (m_ready) begin
        m_valid_q <= 1'b0;
      end
    end
  end

  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign m_last  = m_last_q;
  assign m_sel   = m_sel_q;

endmodule

`default_nettype wire

// File: tb/tb_cm_arb.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_cm_arb : directed self-checking bench for cm_arb                 |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+

module tb_cm_arb;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // u_min: ARB_MIN, packet lock
  logic [3:0]   sv_a = '0, sl_a = '0, sr_a;
  logic [127:0] sd_a = '0;
  logic         mr_a = 1'b1, mv_a, ml_a;
  logic [31:0]  md_a;
  logic [1:0]   ms_a;
  // u_max: ARB_MAX, packet lock
  logic [3:0]   sv_b = '0, sl_b = '0, sr_b;
  logic [127:0] sd_b = '0;
  logic         mr_b = 1'b1, mv_b, ml_b;
  logic [31:0]  md_b;
  logic [1:0]   ms_b;
  // u_nl: ARB_MIN, no packet lock
  logic [3:0]   sv_c = '0, sl_c = '0, sr_c;
  logic [127:0] sd_c = '0;
  logic         mr_c = 1'b1, mv_c, ml_c;
  logic [31:0]  md_c;
  logic [1:0]   ms_c;

  cm_arb #(.N(4), .W(32), .ALGO(cm_pkg::ARB_MIN), .PKT_LOCK(1'b1)) u_min (
    .clk(clk), .rst(rst), .s_valid(sv_a), .s_ready(sr_a), .s_data(sd_a), .s_last(sl_a),
    .m_valid(mv_a), .m_ready(mr_a), .m_data(md_a), .m_last(ml_a), .m_sel(ms_a));

  cm_arb #(.N(4), .W(32), .ALGO(cm_pkg::ARB_MAX), .PKT_LOCK(1'b1)) u_max (
    .clk(clk), .rst(rst), .s_valid(sv_b), .s_ready(sr_b), .s_data(sd_b), .s_last(sl_b),
    .m_valid(mv_b), .m_ready(mr_b), .m_data(md_b), .m_last(ml_b), .m_sel(ms_b));

  cm_arb #(.N(4), .W(32), .ALGO(cm_pkg::ARB_MIN), .PKT_LOCK(1'b0)) u_nl (
    .clk(clk), .rst(rst), .s_valid(sv_c), .s_ready(sr_c), .s_data(sd_c), .s_last(sl_c),
    .m_valid(mv_c), .m_ready(mr_c), .m_data(md_c), .m_last(ml_c), .m_sel(ms_c));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    step(); step();
    chk("rst_mv_a", 64'(mv_a), 64'd0);
    chk("rst_sr_a", 64'(sr_a), 64'd0);
    chk("rst_md_a", 64'(md_a), 64'd0);
    chk("rst_ms_a", 64'(ms_a), 64'd0);
    chk("rst_ml_a", 64'(ml_a), 64'd0);
    chk("rst_mv_b", 64'(mv_b), 64'd0);
    chk("rst_mv_c", 64'(mv_c), 64'd0);
    rst = 1'b0;
    step();

    // MIN, requests on ch1 and ch3, single-beat packets
    sv_a = 4'b1010; sl_a = 4'b1111;
    for (int i = 0; i < 4; i++) sd_a[i*32 +: 32] = 32'hA0 + 32'(i);
    #1;
    chk("t1_idle_sr", 64'(sr_a), 64'h0);
    step();
    chk("t1_lock_sr", 64'(sr_a), 64'b0010);
    chk("t1_mv_c1", 64'(mv_a), 64'd0);
    step();
    chk("t1_mv_c2", 64'(mv_a), 64'd1);
    chk("t1_sel0", 64'(ms_a), 64'd1);
    chk("t1_data0", 64'(md_a), 64'hA1);
    chk("t1_idle_sr2", 64'(sr_a), 64'h0);
    sv_a = 4'b1000;
    step();
    chk("t1_mv_gap", 64'(mv_a), 64'd0);
    chk("t1_lock_sr2", 64'(sr_a), 64'b1000);
    step();
    chk("t1_sel1", 64'(ms_a), 64'd3);
    chk("t1_data1", 64'(md_a), 64'hA3);
    sv_a = 4'b0000;
    step();
    chk("t1_mv_end", 64'(mv_a), 64'd0);

    // MAX picks highest of 0111
    sv_b = 4'b0111; sl_b = 4'b1111;
    for (int i = 0; i < 4; i++) sd_b[i*32 +: 32] = 32'hB0 + 32'(i);
    step();
    chk("t2_sr", 64'(sr_b), 64'b0100);
    step();
    chk("t2_sel", 64'(ms_b), 64'd2);
    chk("t2_data", 64'(md_b), 64'hB2);
    sv_b = 4'b0000;

    // 4-beat packet on ch0 with ch1 arriving mid-packet
    sv_a = 4'b0001; sl_a = 4'b0000;
    sd_a[0 +: 32] = 32'h100;
    step();
    for (int k = 0; k < 4; k++) begin
      sd_a[0 +: 32] = 32'h100 + 32'(k);
      sl_a[0] = (k == 3);
      if (k >= 1) begin
        sv_a[1] = 1'b1; sl_a[1] = 1'b1; sd_a[32 +: 32] = 32'h200;
      end
      #1;
      chk("t3_sr_lock", 64'(sr_a), 64'b0001);
      step();
      chk("t3_mv", 64'(mv_a), 64'd1);
      chk("t3_sel", 64'(ms_a), 64'd0);
      chk("t3_data", 64'(md_a), 64'h100 + 64'(k));
    end
    chk("t3_last", 64'(ml_a), 64'd1);
    sv_a[0] = 1'b0;
    #1;
    chk("t3_idle_sr", 64'(sr_a), 64'h0);
    step();
    chk("t3_ch1_sr", 64'(sr_a), 64'b0010);
    chk("t3_mv_gap", 64'(mv_a), 64'd0);
    step();
    chk("t3_ch1_sel", 64'(ms_a), 64'd1);
    chk("t3_ch1_data", 64'(md_a), 64'h200);
    sv_a = 4'b0000;
    step();

    // Backpressure for 5 cycles with a beat held
    sv_a = 4'b0001; sl_a = 4'b0000; sd_a[0 +: 32] = 32'h300;
    step();
    chk("t4_sr0", 64'(sr_a), 64'b0001);
    step();
    chk("t4_data0", 64'(md_a), 64'h300);
    mr_a = 1'b0; sd_a[0 +: 32] = 32'h301; sl_a[0] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("t4_stall_sr", 64'(sr_a), 64'h0);
      chk("t4_stall_mv", 64'(mv_a), 64'd1);
      chk("t4_stall_data", 64'(md_a), 64'h300);
      step();
    end
    mr_a = 1'b1;
    #1;
    chk("t4_rel_sr", 64'(sr_a), 64'b0001);
    step();
    chk("t4_data1", 64'(md_a), 64'h301);
    chk("t4_mv1", 64'(mv_a), 64'd1);
    chk("t4_last1", 64'(ml_a), 64'd1);
    sv_a = 4'b0000;
    step();
    chk("t4_nodup", 64'(mv_a), 64'd0);

    // No packet lock: ch0 re-granted per beat ahead of ch2
    sv_c = 4'b0101; sl_c = 4'b0000;
    sd_c[64 +: 32] = 32'h600;
    for (int k = 0; k < 3; k++) begin
      sd_c[0 +: 32] = 32'h400 + 32'(k);
      sl_c[0] = (k == 2);
      #1;
      chk("t5_idle_sr", 64'(sr_c), 64'h0);
      step();
      chk("t5_grant0", 64'(sr_c), 64'b0001);
      step();
      chk("t5_sel", 64'(ms_c), 64'd0);
      chk("t5_data", 64'(md_c), 64'h400 + 64'(k));
    end
    sv_c[0] = 1'b0; sl_c[2] = 1'b1;
    step();
    chk("t5_grant2", 64'(sr_c), 64'b0100);
    step();
    chk("t5_sel2", 64'(ms_c), 64'd2);
    chk("t5_data2", 64'(md_c), 64'h600);
    sv_c = 4'b0000;

    // Reset pulse mid-packet
    sv_a = 4'b0100; sl_a = 4'b0000; sd_a[64 +: 32] = 32'h700;
    step();
    step();
    chk("t6_pre_mv", 64'(mv_a), 64'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t6_mv", 64'(mv_a), 64'd0);
    chk("t6_sr", 64'(sr_a), 64'h0);
    chk("t6_data", 64'(md_a), 64'h0);
    sv_a = 4'b0110; sl_a = 4'b0010; sd_a[32 +: 32] = 32'h710;
    step();
    chk("t6_rearb", 64'(sr_a), 64'b0010);
    step();
    chk("t6_sel", 64'(ms_a), 64'd1);
    chk("t6_data1", 64'(md_a), 64'h710);
    sv_a = 4'b0000;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
